// File: rtl/encoder_pkg.sv
// Shared definitions for the pipelined priority encoder.
// Contents:
//   search_dir_e : per-word search direction (SEARCH_MSB=0, SEARCH_LSB=1)
//   out_w()      : result width for a given input width, $clog2(dw)+1
//   payload_w()  : packed width of one stage payload {pos, found[, pop]}
// Optional feature macro: ENCODER_POPCOUNT_EN (adds a popcount field).
package encoder_pkg;

  typedef enum logic {
    SEARCH_MSB = 1'b0,
    SEARCH_LSB = 1'b1
  } search_dir_e;

  function automatic int out_w(input int dw);
    return $clog2(dw) + 1;
  endfunction

  // The payload struct itself is declared in the top module, because its
  // field widths follow DATA_WIDTH. This function gives the matching
  // packed width so the register slice can be sized generically.
  function automatic int payload_w(input int dw);
`ifdef ENCODER_POPCOUNT_EN
    return 2 * out_w(dw) + 1;
`else
    return out_w(dw) + 1;
`endif
  endfunction

endpackage

// File: rtl/encoder_stage.sv
// One valid/ready register slice carrying an opaque payload.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake, in_payload is the data
//   out_valid/out_ready   : downstream handshake, out_payload is the data
// The slice loads whenever it is empty or its contents are being taken,
// so a bubble anywhere lets the upstream side advance.
module encoder_stage #(
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_payload
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      // Payload only moves with a real word; a bubble leaves it as-is.
      if (in_valid) out_payload <= in_payload;
    end
  end

endmodule

// File: rtl/pipelined_priority_encoder.sv
// Pipelined priority encoder with valid/ready streaming.
// Returns the 1-based position of the highest (in_lsb=0) or lowest
// (in_lsb=1) set bit of in_data, 0 when no bit is set, after STAGES
// register slices.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data, in_lsb     : word to encode and its search direction
//   in_valid/in_ready   : input handshake (in_ready is 0 during reset)
//   out_pos, out_found  : result and any-bit-set flag
//   out_pop             : set-bit count (only with ENCODER_POPCOUNT_EN)
//   out_valid/out_ready : output handshake
// Optional feature macro: ENCODER_POPCOUNT_EN.
module pipelined_priority_encoder
  import encoder_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int STAGES     = 2,
  localparam int OUT_W      = out_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_lsb,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out_pos,
  output logic                  out_found,
`ifdef ENCODER_POPCOUNT_EN
  output logic [OUT_W-1:0]      out_pop,
`endif
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = payload_w(DATA_WIDTH);

  typedef struct packed {
    logic [OUT_W-1:0] pos;
    logic             found;
`ifdef ENCODER_POPCOUNT_EN
    logic [OUT_W-1:0] pop;
`endif
  } payload_t;

  // Index 0 is the combinational scan / producer side, index k+1 is the
  // output of slice k, index STAGES is the block output.
  logic     [STAGES:0] vld_pipe;
  logic     [STAGES:0] rdy_pipe;
  payload_t [STAGES:0] pay_pipe;

  search_dir_e dir;
  logic [OUT_W-1:0] scan_pos;
`ifdef ENCODER_POPCOUNT_EN
  logic [OUT_W-1:0] scan_pop;
`endif

  assign dir = search_dir_e'(in_lsb);

  // Last hit wins, so the loop direction picks the priority end.
  always_comb begin
    scan_pos = '0;
    if (dir == SEARCH_LSB) begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--)
        if (in_data[i]) scan_pos = OUT_W'(i + 1);
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++)
        if (in_data[i]) scan_pos = OUT_W'(i + 1);
    end
  end

`ifdef ENCODER_POPCOUNT_EN
  always_comb begin
    scan_pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      scan_pop = scan_pop + OUT_W'(in_data[i]);
  end
`endif

  always_comb begin
    pay_pipe[0]       = '0;
    pay_pipe[0].pos   = scan_pos;
    pay_pipe[0].found = |in_data;
`ifdef ENCODER_POPCOUNT_EN
    pay_pipe[0].pop   = scan_pop;
`endif
  end

  // Reset blocks acceptance so nothing offered during reset is taken.
  assign vld_pipe[0]      = in_valid & ~rst;
  assign in_ready         = rdy_pipe[0] & ~rst;
  assign rdy_pipe[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    encoder_stage #(.PW(PW)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (vld_pipe[k]),
      .in_ready   (rdy_pipe[k]),
      .in_payload (pay_pipe[k]),
      .out_valid  (vld_pipe[k+1]),
      .out_ready  (rdy_pipe[k+1]),
      .out_payload(pay_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_pos   = pay_pipe[STAGES].pos;
  assign out_found = pay_pipe[STAGES].found;
`ifdef ENCODER_POPCOUNT_EN
  assign out_pop   = pay_pipe[STAGES].pop;
`endif

endmodule

// File: tb/tb_pipelined_priority_encoder.sv
// Bench for pipelined_priority_encoder: directed scenarios on an 8-bit,
// 2-stage instance plus randomized traffic on eight width/depth
// configurations scored against a behavioural model.
// Honours ENCODER_POPCOUNT_EN for the out_pop checks.
module tb_pipelined_priority_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: position of the highest set bit is the number of shifts
  // needed to empty the word; the lowest set bit is isolated first.
  function automatic int ref_pos(input logic [63:0] d, input bit lsb);
    logic [63:0] v;
    int p;
    if (d == 64'd0) return 0;
    v = lsb ? (d & (~d + 64'd1)) : d;
    p = 0;
    while (v != 64'd0) begin
      v = v >> 1;
      p++;
    end
    return p;
  endfunction

  // ---------------- directed instance: DATA_WIDTH=8, STAGES=2 -----------
  localparam int D_ST = 2;
  logic       d_rst, d_iv, d_il, d_ir, d_ov, d_or, d_of;
  logic [7:0] d_id;
  logic [3:0] d_op;
`ifdef ENCODER_POPCOUNT_EN
  logic [3:0] d_opop;
`endif

  pipelined_priority_encoder #(.DATA_WIDTH(8), .STAGES(D_ST)) u_dut (
    .clk      (clk),
    .rst      (d_rst),
    .in_data  (d_id),
    .in_lsb   (d_il),
    .in_valid (d_iv),
    .in_ready (d_ir),
    .out_pos  (d_op),
    .out_found(d_of),
`ifdef ENCODER_POPCOUNT_EN
    .out_pop  (d_opop),
`endif
    .out_valid(d_ov),
    .out_ready(d_or)
  );

  logic [7:0] sw[4];
  bit         sl[4];
  int         ep[4];
  bit         ef[4];
  int         epop[4];

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Offer n words back-to-back with out_ready high. A word taken at an
  // edge sits in slice 0, so it is visible at the output D_ST-1 edges
  // later, i.e. D_ST cycles after the cycle in which it was offered.
  task automatic run_stream(input int n, input string nm);
    for (int c = 0; c < n + D_ST; c++) begin
      int k;
      d_iv = (c < n);
      if (c < n) begin
        d_id = sw[c];
        d_il = sl[c];
      end
      #2;
      if (c < n) chk({nm, "_rdy"}, d_ir, 1);
      edge1();
      k = c - (D_ST - 1);
      if (k >= 0 && k < n) begin
        chk({nm, "_vld"}, d_ov, 1);
        chk({nm, "_pos"}, d_op, ep[k]);
        chk({nm, "_fnd"}, d_of, ef[k]);
`ifdef ENCODER_POPCOUNT_EN
        chk({nm, "_pop"}, d_opop, epop[k]);
`endif
      end else begin
        chk({nm, "_idle"}, d_ov, 0);
      end
    end
    d_iv = 1'b0;
  endtask

  initial begin
    d_rst = 1'b1; d_iv = 1'b0; d_il = 1'b0; d_id = '0; d_or = 1'b1;
    #2;
    chk("rst_inrdy", d_ir, 0);
    edge1();
    chk("rst_vld", d_ov, 0);
    chk("rst_pos", d_op, 0);
    chk("rst_fnd", d_of, 0);
    d_rst = 1'b0;
    #2;
    chk("idle_inrdy", d_ir, 1);
    chk("idle_vld", d_ov, 0);
    chk("idle_pos", d_op, 0);
    edge1();

    // MSB-mode stream
    sw = '{8'h00, 8'h01, 8'h80, 8'h3C};
    sl = '{0, 0, 0, 0};
    ep = '{0, 1, 8, 6};
    ef = '{0, 1, 1, 1};
    epop = '{0, 1, 1, 4};
    run_stream(4, "msb");

    // LSB-mode words
    sw[0] = 8'h3C; sw[1] = 8'hFF;
    sl[0] = 1; sl[1] = 1;
    ep[0] = 3; ep[1] = 1;
    ef[0] = 1; ef[1] = 1;
    epop[0] = 4; epop[1] = 8;
    run_stream(2, "lsb");

    // Fill with the consumer stalled
    d_or = 1'b0; d_il = 1'b0; d_iv = 1'b1;
    d_id = 8'h10; #2; chk("fill_rdy0", d_ir, 1); edge1();
    d_id = 8'h20; #2; chk("fill_rdy1", d_ir, 1); edge1();
    d_id = 8'h40; #2; chk("fill_stall", d_ir, 0); edge1();
    chk("fill_vld", d_ov, 1);
    chk("fill_pos", d_op, 5);
    #2; chk("fill_stall2", d_ir, 0); edge1();
    chk("hold_pos", d_op, 5);
    chk("hold_vld", d_ov, 1);
    d_or = 1'b1;
    #2; chk("rel_rdy", d_ir, 1); edge1();
    d_iv = 1'b0;
    chk("rel_pos1", d_op, 6);
    chk("rel_vld1", d_ov, 1);
    edge1();
    chk("rel_pos2", d_op, 7);
    chk("rel_vld2", d_ov, 1);
    edge1();
    chk("rel_empty", d_ov, 0);

    // Reset with two words in flight; the word offered during reset
    // must not be taken either.
    d_iv = 1'b1; d_il = 1'b0;
    d_id = 8'h02; edge1();
    d_id = 8'h04; edge1();
    d_rst = 1'b1; d_id = 8'h08;
    #2; chk("mrst_inrdy", d_ir, 0);
    edge1();
    chk("mrst_vld", d_ov, 0);
    d_rst = 1'b0; d_iv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      edge1();
      chk("mrst_gone", d_ov, 0);
    end

    // Wait for the random runs with a cycle budget
    for (int c = 0; c < 20000 && done < 8; c++) @(posedge clk);
    chk("rnd_timeout", done, 8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- randomized configurations -----------------------------
  for (genvar g = 0; g < 8; g++) begin : g_rnd
    localparam int DW = (g % 4 == 0) ? 1 : (g % 4 == 1) ? 5 : (g % 4 == 2) ? 8 : 32;
    localparam int ST = (g < 4) ? 1 : 3;
    localparam int OW = $clog2(DW) + 1;

    logic          rst, iv, il, ir, ov, ordy, of;
    logic [DW-1:0] id;
    logic [OW-1:0] op;
`ifdef ENCODER_POPCOUNT_EN
    logic [OW-1:0] opop;
`endif

    pipelined_priority_encoder #(.DATA_WIDTH(DW), .STAGES(ST)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (id),
      .in_lsb   (il),
      .in_valid (iv),
      .in_ready (ir),
      .out_pos  (op),
      .out_found(of),
`ifdef ENCODER_POPCOUNT_EN
      .out_pop  (opop),
`endif
      .out_valid(ov),
      .out_ready(ordy)
    );

    initial begin
      int  qpos[$];
      bit  qfnd[$];
      int  qpop[$];
      bit  stall;
      logic [OW-1:0] hpos;
      logic          hfnd;
      rst = 1'b1; iv = 1'b0; il = 1'b0; id = '0; ordy = 1'b0;
      stall = 1'b0; hpos = '0; hfnd = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 10000 + ST + 2; c++) begin
        bit drain;
        drain = (c >= 10000);
        rst  = !drain && ($urandom_range(0, 999) == 0);
        iv   = !drain && ($urandom_range(0, 3) != 0);
        il   = 1'($urandom);
        ordy = !rst && (drain || $urandom_range(0, 3) != 0);
        id   = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
        #2;
        if (rst) chk($sformatf("rnd%0d_rstrdy", g), ir, 0);
        if (ov && qpos.size() == 0) chk($sformatf("rnd%0d_spur", g), ov, 0);
        if (ov && ordy && qpos.size() != 0) begin
          chk($sformatf("rnd%0d_pos", g), op, qpos.pop_front());
          chk($sformatf("rnd%0d_fnd", g), of, qfnd.pop_front());
`ifdef ENCODER_POPCOUNT_EN
          chk($sformatf("rnd%0d_pop", g), opop, qpop.pop_front());
`else
          void'(qpop.pop_front());
`endif
        end
        if (iv && ir) begin
          qpos.push_back(ref_pos(64'(id), il));
          qfnd.push_back(id != '0);
          qpop.push_back($countones(id));
        end
        stall = ov && !ordy && !rst;
        hpos  = op;
        hfnd  = of;
        @(posedge clk);
        #1;
        if (rst) begin
          qpos.delete(); qfnd.delete(); qpop.delete();
          chk($sformatf("rnd%0d_rstvld", g), ov, 0);
        end else if (stall) begin
          chk($sformatf("rnd%0d_holdv", g), ov, 1);
          chk($sformatf("rnd%0d_holdp", g), {op, of}, {hpos, hfnd});
        end
      end
      chk($sformatf("rnd%0d_drain", g), qpos.size(), 0);
      done++;
    end
  end

endmodule
